// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staggered reset sequencer.
// Counter widths are derived per instance from the actual parameter values.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      ST_ASSERT,
      ST_WAIT_RELEASE,
      ST_HOLD,
      ST_RELEASE,
      ST_RUNNING
   } seq_state_t;

   localparam int DEF_RESET_CLKS    = 7;
   localparam int DEF_DEBOUNCE_CLKS = 4;
   localparam int DEF_STAGGER_CLKS  = 2;

   // Width of a down/up counter that must hold values 0..n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reset_debounce.sv
// One reset source: 2-FF synchroniser, polarity normalisation to active-high,
// then a level that only moves after DEBOUNCE_CLKS consecutive agreeing samples.
module reset_debounce
   import reset_seq_pkg::*;
#(
   parameter bit ACTIVE_LOW    = 1'b0,
   parameter int DEBOUNCE_CLKS = DEF_DEBOUNCE_CLKS
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic raw_i,
   output logic level_o
);

   localparam int            DB_W    = cnt_width(DEBOUNCE_CLKS);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CLKS - 1);

   logic [1:0]      sync_q;
   logic [DB_W-1:0] cnt_q;
   logic            norm;

   assign norm = sync_q[1] ^ ACTIVE_LOW;

   // The synchroniser resets to the raw idle level so a quiet source never looks asserted.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         sync_q  <= {2{ACTIVE_LOW}};
         cnt_q   <= '0;
         level_o <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], raw_i};
         if (norm == level_o) begin
            cnt_q <= '0;
         end else if (cnt_q == DB_LAST) begin
            level_o <= norm;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// Reset controller: debounced sources and a soft request trigger a hold period,
// after which the domain resets are released one at a time in index order.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int                 NUM_SRC        = 2,
   parameter logic [NUM_SRC-1:0] SRC_ACTIVE_LOW = 2'b10,
   parameter int                 NUM_DOMAINS    = 3,
   parameter int                 RESET_CLKS     = DEF_RESET_CLKS,
   parameter int                 DEBOUNCE_CLKS  = DEF_DEBOUNCE_CLKS,
   parameter int                 STAGGER_CLKS   = DEF_STAGGER_CLKS,
   parameter int                 CNT_W          = 8
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic [NUM_SRC-1:0]     src_i,
   input  logic                   soft_reset_i,
   output logic [NUM_DOMAINS-1:0] domain_reset_o,
   output logic                   led_reset_o,
   output logic                   reset_done_o,
   output logic [NUM_SRC:0]       reset_cause_o,
   output logic [CNT_W-1:0]       reset_count_o
);

   localparam int HOLD_W = cnt_width(RESET_CLKS);
   localparam int STAG_W = cnt_width(STAGGER_CLKS);
   localparam int IDX_W  = cnt_width(NUM_DOMAINS);

   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_CLKS - 1);
   localparam logic [STAG_W-1:0] STAG_LOAD = STAG_W'(STAGGER_CLKS - 1);
   localparam logic [IDX_W-1:0]  LAST_DOM  = IDX_W'(NUM_DOMAINS - 1);

   seq_state_t          state_q;
   logic [HOLD_W-1:0]   hold_cnt_q;
   logic [STAG_W-1:0]   stag_cnt_q;
   logic [IDX_W-1:0]    dom_idx_q;
   logic                src_any_q;
   logic [NUM_SRC-1:0]  src_level;
   logic                src_any;
   logic                reassert;
   logic                run_trigger;

   for (genvar g = 0; g < NUM_SRC; g++) begin : gen_src
      reset_debounce #(
         .ACTIVE_LOW    (SRC_ACTIVE_LOW[g]),
         .DEBOUNCE_CLKS (DEBOUNCE_CLKS)
      ) u_debounce (
         .clk_i     (clk_i),
         .reset_n_i (reset_n_i),
         .raw_i     (src_i[g]),
         .level_o   (src_level[g])
      );
   end

   assign src_any     = |src_level;
   assign reassert    = src_any | soft_reset_i;
   assign run_trigger = (src_any & ~src_any_q) | soft_reset_i;

   // Outputs are updated alongside every transition so they always describe the state being entered.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q        <= ST_ASSERT;
         hold_cnt_q     <= '0;
         stag_cnt_q     <= '0;
         dom_idx_q      <= '0;
         src_any_q      <= 1'b0;
         domain_reset_o <= '1;
         led_reset_o    <= 1'b1;
         reset_done_o   <= 1'b0;
         reset_cause_o  <= '0;
         reset_count_o  <= '0;
      end else begin
         src_any_q <= src_any;
         unique case (state_q)
            ST_ASSERT: begin
               state_q <= ST_WAIT_RELEASE;
            end

            ST_WAIT_RELEASE: begin
               if (!src_any) begin
                  state_q    <= ST_HOLD;
                  hold_cnt_q <= HOLD_LOAD;
               end
            end

            ST_HOLD: begin
               if (reassert) begin
                  state_q        <= ST_ASSERT;
                  domain_reset_o <= '1;
                  led_reset_o    <= 1'b1;
                  reset_cause_o  <= reset_cause_o | {soft_reset_i, src_level};
               end else if (hold_cnt_q == '0) begin
                  domain_reset_o[0] <= 1'b0;
                  dom_idx_q         <= IDX_W'(1);
                  stag_cnt_q        <= STAG_LOAD;
                  if (NUM_DOMAINS == 1) begin
                     state_q      <= ST_RUNNING;
                     led_reset_o  <= 1'b0;
                     reset_done_o <= 1'b1;
                  end else begin
                     state_q <= ST_RELEASE;
                  end
               end else begin
                  hold_cnt_q <= hold_cnt_q - 1'b1;
               end
            end

            ST_RELEASE: begin
               if (reassert) begin
                  state_q        <= ST_ASSERT;
                  domain_reset_o <= '1;
                  led_reset_o    <= 1'b1;
                  reset_cause_o  <= reset_cause_o | {soft_reset_i, src_level};
               end else if (stag_cnt_q == '0) begin
                  domain_reset_o[dom_idx_q] <= 1'b0;
                  if (dom_idx_q == LAST_DOM) begin
                     state_q      <= ST_RUNNING;
                     led_reset_o  <= 1'b0;
                     reset_done_o <= 1'b1;
                  end else begin
                     dom_idx_q  <= dom_idx_q + 1'b1;
                     stag_cnt_q <= STAG_LOAD;
                  end
               end else begin
                  stag_cnt_q <= stag_cnt_q - 1'b1;
               end
            end

            ST_RUNNING: begin
               if (run_trigger) begin
                  state_q        <= ST_ASSERT;
                  domain_reset_o <= '1;
                  led_reset_o    <= 1'b1;
                  reset_done_o   <= 1'b0;
                  reset_cause_o  <= {soft_reset_i, src_level};
                  if (reset_count_o != '1) begin
                     reset_count_o <= reset_count_o + 1'b1;
                  end
               end
            end

            default: begin
               state_q <= ST_ASSERT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus random source
// activity, all compared against a timeline-based behavioural model.
module tb_reset_sequencer;

   localparam int NS = 2;
   localparam int ND = 3;
   localparam int RC = 7;
   localparam int DB = 4;
   localparam int ST = 2;
   localparam int CW = 8;
   localparam logic [NS-1:0] POL  = 2'b10;
   localparam logic [NS-1:0] IDLE = 2'b10;
   localparam logic [15:0]   RESET_VEC = {3'b111, 1'b1, 1'b0, 3'b000, 8'h00};

   logic          clk = 1'b0;
   logic          reset_n_i;
   logic [NS-1:0] src_i;
   logic          soft_reset_i;
   logic [ND-1:0] domain_reset_o;
   logic          led_reset_o;
   logic          reset_done_o;
   logic [NS:0]   reset_cause_o;
   logic [CW-1:0] reset_count_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reset_sequencer #(
      .NUM_SRC        (NS),
      .SRC_ACTIVE_LOW (POL),
      .NUM_DOMAINS    (ND),
      .RESET_CLKS     (RC),
      .DEBOUNCE_CLKS  (DB),
      .STAGGER_CLKS   (ST),
      .CNT_W          (CW)
   ) dut (
      .clk_i          (clk),
      .reset_n_i      (reset_n_i),
      .src_i          (src_i),
      .soft_reset_i   (soft_reset_i),
      .domain_reset_o (domain_reset_o),
      .led_reset_o    (led_reset_o),
      .reset_done_o   (reset_done_o),
      .reset_cause_o  (reset_cause_o),
      .reset_count_o  (reset_count_o)
   );

   wire [15:0] act_vec = {domain_reset_o, led_reset_o, reset_done_o, reset_cause_o, reset_count_o};

   // Model: raw history for debouncing, and a timeline counter m_t measured from hold start.
   logic [NS-1:0] m_hist[$];
   logic [NS-1:0] m_lvl;
   bit            m_prev;
   bit            m_asrt;
   bit            m_wait;
   int            m_t;
   logic [NS:0]   m_cause;
   logic [CW-1:0] m_count;

   function automatic logic [15:0] exp_vec();
      logic [ND-1:0] d;
      logic          dn;
      for (int k = 0; k < ND; k++)
         d[k] = (m_asrt || m_wait) ? 1'b1 : 1'(m_t < RC + k * ST);
      dn = !(m_asrt || m_wait) && (m_t >= RC + (ND - 1) * ST);
      return {d, |d, dn, m_cause, m_count};
   endfunction

   always @(posedge clk or negedge reset_n_i) begin : model
      logic [NS-1:0] nl;
      bit any, flip, running;
      if (!reset_n_i) begin
         m_hist.delete();
         repeat (DB + 2) m_hist.push_back('0);
         m_lvl   = '0;
         m_prev  = 0;
         m_asrt  = 1;
         m_wait  = 0;
         m_t     = -1;
         m_cause = '0;
         m_count = '0;
      end else begin
         any = |m_lvl;
         running = !m_asrt && !m_wait && (m_t >= RC + (ND - 1) * ST);
         m_hist.push_back(src_i ^ POL);
         nl = m_lvl;
         for (int i = 0; i < NS; i++) begin
            flip = 1;
            for (int k = 0; k < DB; k++)
               if (m_hist[m_hist.size() - 3 - k][i] == m_lvl[i]) flip = 0;
            if (flip) nl[i] = ~m_lvl[i];
         end
         while (m_hist.size() > DB + 2) void'(m_hist.pop_front());
         if (m_asrt) begin
            m_asrt = 0;
            m_wait = 1;
         end else if (m_wait) begin
            if (!any) begin
               m_wait = 0;
               m_t    = 0;
            end
         end else if (!running) begin
            if (any || soft_reset_i) begin
               m_asrt  = 1;
               m_cause = m_cause | {soft_reset_i, m_lvl};
            end else begin
               m_t++;
            end
         end else if ((any && !m_prev) || soft_reset_i) begin
            m_asrt  = 1;
            m_cause = {soft_reset_i, m_lvl};
            if (m_count != '1) m_count++;
         end
         m_prev = any;
         m_lvl  = nl;
      end
   end

   task automatic test_reset();
      reset_n_i    = 1'b0;
      src_i        = IDLE;
      soft_reset_i = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (act_vec !== RESET_VEC) begin
         errors++;
         $display("[TB] FAIL reset_values: got %h expected %h", act_vec, RESET_VEC);
      end
   endtask

   task automatic test_power_on();
      logic [ND-1:0] exp_dom;
      reset_n_i = 1'b1;
      #1;
      for (int c = 0; c <= 16; c++) begin
         if (c > 0) @(negedge clk);
         exp_dom = (c < 9) ? 3'b111 : (c < 11) ? 3'b110 : (c < 13) ? 3'b100 : 3'b000;
         checks++;
         if (domain_reset_o !== exp_dom || reset_done_o !== 1'(c >= 13) || reset_count_o !== 8'd0) begin
            errors++;
            $display("[TB] FAIL power_on_timeline c=%0d: got dom=%b done=%b cnt=%0d expected dom=%b done=%b cnt=0",
                     c, domain_reset_o, reset_done_o, reset_count_o, exp_dom, c >= 13);
         end
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL power_on_model c=%0d: got %h expected %h", c, act_vec, exp_vec());
         end
      end
   endtask

   task automatic test_debounce();
      int n;
      src_i[0] = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 3) src_i[0] = 1'b0;
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL debounce_short_model c=%0d: got %h expected %h", c, act_vec, exp_vec());
         end
      end
      checks++;
      if (reset_done_o !== 1'b1 || reset_count_o !== 8'd0) begin
         errors++;
         $display("[TB] FAIL debounce_short_ignored: got done=%b cnt=%0d expected done=1 cnt=0",
                  reset_done_o, reset_count_o);
      end
      src_i[0] = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         if (c == 4) src_i[0] = 1'b0;
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL debounce_long_model c=%0d: got %h expected %h", c, act_vec, exp_vec());
         end
         if (c == 6) begin
            checks++;
            if (reset_done_o !== 1'b1) begin
               errors++;
               $display("[TB] FAIL debounce_not_early: got done=%b expected 1", reset_done_o);
            end
         end
         if (c == 7) begin
            checks++;
            if ({domain_reset_o, reset_done_o, reset_cause_o, reset_count_o} !== {3'b111, 1'b0, 3'b001, 8'd1}) begin
               errors++;
               $display("[TB] FAIL debounce_assert: got dom=%b done=%b cause=%b cnt=%0d expected dom=111 done=0 cause=001 cnt=1",
                        domain_reset_o, reset_done_o, reset_cause_o, reset_count_o);
            end
         end
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL debounce_recover_model n=%0d: got %h expected %h", n, act_vec, exp_vec());
         end
      end while (reset_done_o !== 1'b1 && n < 100);
      checks++;
      if (reset_done_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL debounce_timeout: got done=%b expected 1", reset_done_o);
      end
   endtask

   task automatic test_held_button();
      int n;
      src_i[1] = 1'b0;
      for (int c = 1; c <= 50; c++) begin
         @(negedge clk);
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL held_model c=%0d: got %h expected %h", c, act_vec, exp_vec());
         end
         if (c >= 7) begin
            checks++;
            if (domain_reset_o !== 3'b111 || reset_done_o !== 1'b0) begin
               errors++;
               $display("[TB] FAIL held_wait c=%0d: got dom=%b done=%b expected dom=111 done=0",
                        c, domain_reset_o, reset_done_o);
            end
         end
      end
      src_i[1] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL held_release_model n=%0d: got %h expected %h", n, act_vec, exp_vec());
         end
      end while (reset_done_o !== 1'b1 && n < 100);
      checks++;
      if (reset_done_o !== 1'b1 || reset_cause_o !== 3'b010 || reset_count_o !== 8'd2) begin
         errors++;
         $display("[TB] FAIL held_result: got done=%b cause=%b cnt=%0d expected done=1 cause=010 cnt=2",
                  reset_done_o, reset_cause_o, reset_count_o);
      end
   endtask

   task automatic test_soft_reset();
      int n;
      soft_reset_i = 1'b1;
      @(negedge clk);
      soft_reset_i = 1'b0;
      checks++;
      if ({domain_reset_o, reset_done_o, reset_cause_o, reset_count_o} !== {3'b111, 1'b0, 3'b100, 8'd3}) begin
         errors++;
         $display("[TB] FAIL soft_assert: got dom=%b done=%b cause=%b cnt=%0d expected dom=111 done=0 cause=100 cnt=3",
                  domain_reset_o, reset_done_o, reset_cause_o, reset_count_o);
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL soft_model n=%0d: got %h expected %h", n, act_vec, exp_vec());
         end
      end while (reset_done_o !== 1'b1 && n < 100);
      checks++;
      if (reset_done_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL soft_timeout: got done=%b expected 1", reset_done_o);
      end
   endtask

   task automatic test_mid_release();
      int n;
      soft_reset_i = 1'b1;
      @(negedge clk);
      soft_reset_i = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL mid_release_model n=%0d: got %h expected %h", n, act_vec, exp_vec());
         end
      end while (domain_reset_o !== 3'b110 && n < 40);
      checks++;
      if (domain_reset_o !== 3'b110) begin
         errors++;
         $display("[TB] FAIL mid_release_reach: got dom=%b expected 110", domain_reset_o);
      end
      soft_reset_i = 1'b1;
      @(negedge clk);
      soft_reset_i = 1'b0;
      checks++;
      if ({domain_reset_o, led_reset_o, reset_cause_o, reset_count_o} !== {3'b111, 1'b1, 3'b100, 8'd4}) begin
         errors++;
         $display("[TB] FAIL mid_release_reassert: got dom=%b led=%b cause=%b cnt=%0d expected dom=111 led=1 cause=100 cnt=4",
                  domain_reset_o, led_reset_o, reset_cause_o, reset_count_o);
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL mid_release_recover n=%0d: got %h expected %h", n, act_vec, exp_vec());
         end
      end while (reset_done_o !== 1'b1 && n < 100);
   endtask

   task automatic test_random();
      int n;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 7) == 0) src_i[$urandom_range(0, NS - 1)] ^= 1'b1;
         soft_reset_i = ($urandom_range(0, 39) == 0);
         @(negedge clk);
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL random_model c=%0d src=%b: got %h expected %h", c, src_i, act_vec, exp_vec());
         end
      end
      src_i        = IDLE;
      soft_reset_i = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL random_settle_model n=%0d: got %h expected %h", n, act_vec, exp_vec());
         end
      end while (reset_done_o !== 1'b1 && n < 200);
      checks++;
      if (reset_done_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL random_timeout: got done=%b expected 1", reset_done_o);
      end
   endtask

   task automatic test_saturation();
      int n;
      for (int e = 0; e < 300; e++) begin
         soft_reset_i = 1'b1;
         @(negedge clk);
         soft_reset_i = 1'b0;
         n = 0;
         do begin
            @(negedge clk);
            n++;
            checks++;
            if (act_vec !== exp_vec()) begin
               errors++;
               $display("[TB] FAIL saturation_model e=%0d n=%0d: got %h expected %h", e, n, act_vec, exp_vec());
            end
         end while (reset_done_o !== 1'b1 && n < 100);
      end
      checks++;
      if (reset_count_o !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL saturation_count: got %0d expected 255", reset_count_o);
      end
   endtask

   task automatic test_async_mid_hold();
      soft_reset_i = 1'b1;
      @(negedge clk);
      soft_reset_i = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (domain_reset_o !== 3'b111 || reset_done_o !== 1'b0 || reset_count_o !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL async_pre_hold: got dom=%b done=%b cnt=%0d expected dom=111 done=0 cnt=255",
                  domain_reset_o, reset_done_o, reset_count_o);
      end
      #2 reset_n_i = 1'b0;
      #1;
      checks++;
      if (act_vec !== RESET_VEC) begin
         errors++;
         $display("[TB] FAIL async_reset_values: got %h expected %h", act_vec, RESET_VEC);
      end
      repeat (2) @(negedge clk);
      reset_n_i = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL async_restart_model c=%0d: got %h expected %h", c, act_vec, exp_vec());
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_power_on();
      test_debounce();
      test_held_button();
      test_soft_reset();
      test_mid_release();
      test_random();
      test_saturation();
      test_async_mid_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
